// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared constants and types for the load/store unit: data-bus mode encodings,
// access-size encodings, the controller state enum and the alignment rule.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR,
        ST_RESP
    } lsu_state_t;

    // Halves must sit on even addresses, words on multiples of four; the
    // reserved size code is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane handling for the load/store unit.
//   rd_word     in  32  word captured from the data bus
//   addr_lo     in  2   byte offset of the access inside the word
//   size        in  2   access size (byte / half / word)
//   is_unsigned in  1   zero-extend instead of sign-extend sub-word loads
//   st_data     in  32  right-justified store data
//   ld_data     out 32  extracted and extended load result
//   merged_word out 32  rd_word with the store bytes placed in their lanes
//                       (the plain store word for word-sized accesses)
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged_word
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rd_word[{addr_lo, 3'b000} +: 8];
        half_s = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            SIZE_B:  ld_data = is_unsigned ? {24'd0, byte_s}
                                           : {{24{byte_s[7]}}, byte_s};
            SIZE_H:  ld_data = is_unsigned ? {16'd0, half_s}
                                           : {{16{half_s[15]}}, half_s};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        merged_word = rd_word;
        case (size)
            SIZE_B:  merged_word[{addr_lo, 3'b000} +: 8] = st_data[7:0];
            SIZE_H:  merged_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
            default: merged_word = st_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-bus initiator: takes one load/store request at a time from the core and
// runs it as read/write cycles on the shared data bus. Sub-word stores are a
// read-modify-write because the bus only moves whole words.
//   clk            in    1   rising-edge clock
//   reset          in    1   synchronous, active-low
//   req_valid      in    1   request present
//   req_ready      out   1   high only when idle and out of reset
//   req_store      in    1   1 = store, 0 = load
//   req_size       in    2   00 byte, 01 half, 10 word, 11 rejected
//   req_unsigned   in    1   zero-extend sub-word loads
//   req_addr       in    32  byte address
//   req_wdata      in    32  right-justified store data
//   resp_valid     out   1   one-cycle completion pulse
//   resp_rdata     out   32  load result, 0 for stores and errors
//   resp_error     out   1   misaligned access
//   data_bus_data  inout 32  driven only during a write cycle
//   data_bus_addr  out   32  word-aligned bus address
//   data_bus_mode  out   2   00 idle, 01 read, 10 write (registered)
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    inout  wire  [31:0] data_bus_data,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode
);

    lsu_state_t  state;

    // Request fields held from accept until the response.
    logic        lat_store;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_addr_lo;
    logic [31:0] lat_wdata;

    logic [31:0] bus_wdata;
    logic [31:0] ld_data;
    logic [31:0] merged_word;

    assign req_ready = (state == ST_IDLE) && reset;

    // The bus is only ever driven while the registered mode says write, so a
    // reset or any other state releases it on the following cycle.
    assign data_bus_data = (data_bus_mode == BUS_WRITE) ? bus_wdata : 'z;

    // The bus word is only consumed in RD_D, where it is the responder's data.
    lsu_lane_align u_lane_align (
        .rd_word     (data_bus_data),
        .addr_lo     (lat_addr_lo),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .st_data     (lat_wdata),
        .ld_data     (ld_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            data_bus_mode <= BUS_IDLE;
            data_bus_addr <= 32'd0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_error    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_store     <= req_store;
                        lat_size      <= req_size;
                        lat_unsigned  <= req_unsigned;
                        lat_addr_lo   <= req_addr[1:0];
                        lat_wdata     <= req_wdata;
                        data_bus_addr <= {req_addr[31:2], 2'b00};
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                            resp_error <= 1'b1;
                        end else if (req_store && (req_size == SIZE_W)) begin
                            state         <= ST_WR;
                            data_bus_mode <= BUS_WRITE;
                            bus_wdata     <= req_wdata;
                        end else begin
                            state         <= ST_RD_A;
                            data_bus_mode <= BUS_READ;
                        end
                    end
                end
                ST_RD_A: begin
                    state <= ST_RD_D;
                end
                ST_RD_D: begin
                    if (lat_store) begin
                        state         <= ST_WR;
                        data_bus_mode <= BUS_WRITE;
                        bus_wdata     <= merged_word;
                    end else begin
                        state         <= ST_RESP;
                        data_bus_mode <= BUS_IDLE;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= ld_data;
                        resp_error    <= 1'b0;
                    end
                end
                ST_WR: begin
                    state         <= ST_RESP;
                    data_bus_mode <= BUS_IDLE;
                    resp_valid    <= 1'b1;
                    resp_rdata    <= 32'd0;
                    resp_error    <= 1'b0;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state         <= ST_IDLE;
                    data_bus_mode <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Bench for load_store_unit with a word-addressed data RAM on the bus side and
// a reference memory that tracks what the RAM should contain.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [31:0] IDLE_PAT = 32'h5A5A_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    wire  [31:0] data_bus_data;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .data_bus_data (data_bus_data),
        .data_bus_addr (data_bus_addr),
        .data_bus_mode (data_bus_mode)
    );

    // ---------------- bus-side RAM ----------------
    logic [31:0] mem_val     [0:1023];
    bit          mem_written [0:1023];

    function automatic logic [31:0] init_val(input int i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] bus_word(input int i);
        return mem_written[i] ? mem_val[i] : init_val(i);
    endfunction

    logic [9:0]  bus_idx;
    logic [31:0] tb_drive;
    assign bus_idx  = data_bus_addr[11:2];
    assign tb_drive = (data_bus_mode == 2'b01) ? bus_word(int'(bus_idx)) : IDLE_PAT;
    assign data_bus_data = (data_bus_mode != 2'b10) ? tb_drive : 'z;

    int          rd_total   = 0;
    int          wr_total   = 0;
    int          resp_total = 0;
    int          drive_bad  = 0;
    logic [31:0] last_wdata = 32'd0;

    always @(posedge clk) begin
        if (data_bus_mode == 2'b01) rd_total <= rd_total + 1;
        if (data_bus_mode == 2'b10) begin
            wr_total             <= wr_total + 1;
            last_wdata           <= data_bus_data;
            mem_val[bus_idx]     <= data_bus_data;
            mem_written[bus_idx] <= 1'b1;
        end
        if (resp_valid) resp_total <= resp_total + 1;
    end

    // Outside write cycles the bus must carry exactly what the RAM side drives.
    always @(negedge clk) begin
        if (data_bus_mode != 2'b10 && data_bus_data !== tb_drive)
            drive_bad <= drive_bad + 1;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input string tag, output logic [31:0] obs_rdata);
        int          w, lat, rd0, wr0, idx, sh;
        int          exp_lat, exp_rd, exp_wr;
        logic        mis;
        logic [31:0] old, mask, nw, exp_rdata, v;

        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);

        idx  = int'(addr[11:2]);
        sh   = 8 * int'(addr[1:0]);
        old  = ref_mem[idx];
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mis  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        nw   = old;
        exp_rdata = 32'd0;
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (st) begin
            nw = (old & ~(mask << sh)) | ((wd & mask) << sh);
            if (sz == 2'd2) begin exp_lat = 2; exp_rd = 0; end
            else            begin exp_lat = 4; exp_rd = 2; end
            exp_wr = 1;
        end else begin
            v = (old >> sh) & mask;
            if (!un && sz == 2'd0 && v[7])  v = v | ~mask;
            if (!un && sz == 2'd1 && v[15]) v = v | ~mask;
            exp_rdata = v;
            exp_lat = 3; exp_rd = 2; exp_wr = 0;
        end

        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = addr;
        req_wdata    = wd;
        rd0 = rd_total;
        wr0 = wr_total;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_store    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 8);

        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".error"}, {31'd0, resp_error}, {31'd0, mis});
        check({tag, ".resp_mode"}, {30'd0, data_bus_mode}, 32'd0);
        check({tag, ".resp_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, ".reads"}, rd_total - rd0, exp_rd);
        check({tag, ".writes"}, wr_total - wr0, exp_wr);
        if (exp_wr == 1) check({tag, ".wdata"}, last_wdata, nw);
        ref_mem[idx] = nw;
        check({tag, ".ram"}, bus_word(idx), nw);
        obs_rdata = resp_rdata;

        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int          wr0, resp0;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        repeat (3) @(negedge clk);

        check("rst.mode",  {30'd0, data_bus_mode}, 32'd0);
        check("rst.addr",  data_bus_addr, 32'd0);
        check("rst.valid", {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.error", {31'd0, resp_error}, 32'd0);
        check("rst.ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Word round trip
        do_req(1'b1, 2'd2, 1'b0, 32'h2004, 32'hDEAD_BEEF, "sw2004", r);
        do_req(1'b0, 2'd2, 1'b0, 32'h2004, 32'h0, "lw2004", r);
        check("lw2004.const", r, 32'hDEAD_BEEF);

        // Byte read-modify-write
        do_req(1'b1, 2'd2, 1'b0, 32'h2008, 32'h1122_3344, "sw2008", r);
        do_req(1'b1, 2'd0, 1'b0, 32'h200A, 32'h1234_56AA, "sb200a", r);
        check("sb200a.const", last_wdata, 32'h11AA_3344);
        do_req(1'b1, 2'd1, 1'b0, 32'h200A, 32'hCAFE_F00D, "sh200a", r);

        // Sign / zero extension
        do_req(1'b1, 2'd2, 1'b0, 32'h200C, 32'h80FF_7F01, "sw200c", r);
        do_req(1'b0, 2'd0, 1'b0, 32'h200D, 32'h0, "lb200d", r);
        check("lb200d.const", r, 32'h0000_007F);
        do_req(1'b0, 2'd0, 1'b0, 32'h200E, 32'h0, "lb200e", r);
        check("lb200e.const", r, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd1, 1'b1, 32'h200E, 32'h0, "lhu200e", r);
        check("lhu200e.const", r, 32'h0000_80FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h200E, 32'h0, "lh200e", r);
        check("lh200e.const", r, 32'hFFFF_80FF);
        do_req(1'b0, 2'd0, 1'b1, 32'h200F, 32'h0, "lbu200f", r);
        check("lbu200f.const", r, 32'h0000_0080);

        // Misaligned accesses
        do_req(1'b0, 2'd1, 1'b0, 32'h2001, 32'h0, "lh2001", r);
        do_req(1'b1, 2'd2, 1'b0, 32'h2006, 32'h1357_9BDF, "sw2006", r);
        do_req(1'b0, 2'd3, 1'b0, 32'h2000, 32'h0, "sz3", r);

        // Reset during RD_D of a byte store
        wr0   = wr_total;
        resp0 = resp_total;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr  = 32'h2011; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort.rd_a_mode", {30'd0, data_bus_mode}, 32'd1);
        @(negedge clk);
        check("abort.rd_d_mode", {30'd0, data_bus_mode}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort.mode",  {30'd0, data_bus_mode}, 32'd0);
        check("abort.valid", {31'd0, resp_valid}, 32'd0);
        check("abort.ready_in_rst", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort.ready_after", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("abort.writes", wr_total - wr0, 0);
        check("abort.resps",  resp_total - resp0, 0);
        check("abort.ram",    bus_word(4), ref_mem[4]);
        do_req(1'b0, 2'd2, 1'b0, 32'h2010, 32'h0, "lw2010", r);

        // Randomized traffic over a small window so accesses collide
        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   32'h2000 + ($urandom % 32), $urandom, $sformatf("rnd%0d", n), r);
        end

        check("bus.release", drive_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
